// File: rtl/lab1_idiv_pkg.sv
// Shared types and message-field layout for the lab1 iterative integer divider.
// Field indices assume the default 32-bit operand width.
package lab1_idiv_pkg;

   localparam int NBITS = 32;
   localparam int CNT_W = $clog2(NBITS);

   // Request: {signed, a, b}; response: {remainder, quotient}
   localparam int SIGN_BIT = 2*NBITS;
   localparam int A_MSB    = 2*NBITS-1;
   localparam int A_LSB    = NBITS;
   localparam int B_MSB    = NBITS-1;
   localparam int B_LSB    = 0;
   localparam int REM_MSB  = 2*NBITS-1;
   localparam int REM_LSB  = NBITS;
   localparam int QUO_MSB  = NBITS-1;
   localparam int QUO_LSB  = 0;

   localparam logic [NBITS-1:0] INT_MIN = {1'b1, {(NBITS-1){1'b0}}};
   localparam logic [NBITS-1:0] NEG_ONE = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Single-letter state name used by line tracing.
   function automatic logic [7:0] state_letter(state_t s);
      case (s)
         IDLE:    return 8'h49;
         CALC:    return 8'h43;
         DONE:    return 8'h44;
         default: return 8'h3F;
      endcase
   endfunction

endpackage

// File: rtl/lab1_idiv_int_div_iter_dpath.sv
// Divider datapath: operand magnitudes, restoring shift/subtract loop,
// iteration counter, sign/special-case flags and the result fix-up.
module lab1_idiv_int_div_iter_dpath
   import lab1_idiv_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic               i_iter,
   input  logic [2*NBITS:0]   i_req_msg,
   output logic [2*NBITS-1:0] o_resp_msg,
   output logic               o_cnt_is_max
);

   logic [NBITS-1:0] r_q, r_r, r_d, r_a;
   logic [CNT_W-1:0] r_cnt;
   logic             r_neg_q, r_neg_r, r_div0, r_ovf;

   logic             w_sgn;
   logic [NBITS-1:0] w_a, w_b, w_a_mag, w_b_mag;
   logic [NBITS:0]   w_t;
   logic             w_ge;
   logic [NBITS-1:0] w_rem_next;
   logic [NBITS-1:0] w_quo_fix, w_rem_fix;

   assign w_sgn   = i_req_msg[SIGN_BIT];
   assign w_a     = i_req_msg[A_MSB:A_LSB];
   assign w_b     = i_req_msg[B_MSB:B_LSB];
   assign w_a_mag = (w_sgn && w_a[NBITS-1]) ? -w_a : w_a;
   assign w_b_mag = (w_sgn && w_b[NBITS-1]) ? -w_b : w_b;

   // Full 33-bit partial remainder so divisors with the top bit set still work
   assign w_t        = {r_r, r_q[NBITS-1]};
   assign w_ge       = (w_t >= {1'b0, r_d});
   assign w_rem_next = w_ge ? (w_t[NBITS-1:0] - r_d) : w_t[NBITS-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q     <= '0;
         r_r     <= '0;
         r_d     <= '0;
         r_a     <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_div0  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (i_load) begin
         r_q     <= w_a_mag;
         r_r     <= '0;
         r_d     <= w_b_mag;
         r_a     <= w_a;
         r_cnt   <= '0;
         r_neg_q <= w_sgn & (w_a[NBITS-1] ^ w_b[NBITS-1]);
         r_neg_r <= w_sgn & w_a[NBITS-1];
         r_div0  <= (w_b == '0);
         r_ovf   <= w_sgn & (w_a == INT_MIN) & (w_b == NEG_ONE);
      end else if (i_iter) begin
         r_q   <= {r_q[NBITS-2:0], w_ge};
         r_r   <= w_rem_next;
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt_is_max = (r_cnt == '1);

   assign w_quo_fix = r_neg_q ? -r_q : r_q;
   assign w_rem_fix = r_neg_r ? -r_r : r_r;

   always_comb begin
      o_resp_msg = '0;
      if (r_div0) begin
         o_resp_msg[REM_MSB:REM_LSB] = r_a;
         o_resp_msg[QUO_MSB:QUO_LSB] = NEG_ONE;
      end else if (r_ovf) begin
         o_resp_msg[REM_MSB:REM_LSB] = '0;
         o_resp_msg[QUO_MSB:QUO_LSB] = INT_MIN;
      end else begin
         o_resp_msg[REM_MSB:REM_LSB] = w_rem_fix;
         o_resp_msg[QUO_MSB:QUO_LSB] = w_quo_fix;
      end
   end

endmodule

// File: rtl/lab1_idiv_int_div_iter.sv
// Iterative 32-cycle signed/unsigned divider with val/rdy request and
// response ports; the FSM here sequences load, iterate and hand-off.
module lab1_idiv_int_div_iter
   import lab1_idiv_pkg::*;
#(
   parameter int nbits = NBITS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_val,
   output logic               req_rdy,
   input  logic [2*nbits:0]   req_msg,
   output logic               resp_val,
   input  logic               resp_rdy,
   output logic [2*nbits-1:0] resp_msg
);

   state_t r_state, w_state_next;
   logic   w_load, w_iter, w_cnt_is_max;
   logic [7:0] w_trace_state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      req_rdy      = 1'b0;
      resp_val     = 1'b0;
      w_load       = 1'b0;
      w_iter       = 1'b0;
      case (r_state)
         IDLE: begin
            req_rdy = 1'b1;
            w_load  = req_val;
            if (req_val) w_state_next = CALC;
         end
         CALC: begin
            w_iter = 1'b1;
            if (w_cnt_is_max) w_state_next = DONE;
         end
         DONE: begin
            resp_val = 1'b1;
            if (resp_rdy) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State letter for line tracing alongside the dpath A/R registers
   assign w_trace_state = state_letter(r_state);

   lab1_idiv_int_div_iter_dpath u_dpath (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_load),
      .i_iter       (w_iter),
      .i_req_msg    (req_msg),
      .o_resp_msg   (resp_msg),
      .o_cnt_is_max (w_cnt_is_max)
   );

   logic w_unused;
   assign w_unused = ^w_trace_state;

endmodule

// File: tb/tb_lab1_idiv_int_div_iter.sv
// Scoreboard bench for the iterative divider: stimulus pushes expected
// responses, a monitor pops and compares on each response handshake.
module tb_lab1_idiv_int_div_iter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_val = 1'b0;
   logic        req_rdy;
   logic [64:0] req_msg = '0;
   logic        resp_val;
   logic        resp_rdy = 1'b0;
   logic [63:0] resp_msg;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int accept_cyc = 0;
   bit rand_sink = 1'b0;
   logic [63:0] sb[$];

   lab1_idiv_int_div_iter #(.nbits(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_msg  (req_msg),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_msg (resp_msg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Reference: plain integer division semantics plus the special cases
   function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      int signed sa, sbv;
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (!sgn) return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      sa  = $signed(a);
      sbv = $signed(b);
      return {32'(sa % sbv), 32'(sa / sbv)};
   endfunction

   // Monitor: compare every response handshake against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (reset && resp_val && resp_rdy) begin
            if (sb.size() == 0) chk("unexpected_resp", resp_msg, 64'hx);
            else chk("resp_msg", resp_msg, sb.pop_front());
         end
      end
   end

   // Random sink backpressure
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_sink) resp_rdy = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
      int n;
      n = 0;
      req_val = 1'b1;
      req_msg = {sgn, a, b};
      while (!req_rdy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_rdy) begin
         chk("req_rdy_timeout", 64'(req_rdy), 64'd1);
         req_val = 1'b0;
         return;
      end
      @(posedge clk);
      sb.push_back(exp);
      #1;
      accept_cyc = cyc;
      req_val = 1'b0;
      req_msg = $urandom();
   endtask

   task automatic check_latency(input string name);
      int n;
      n = 0;
      while (!resp_val && n < 40) begin
         chk({name, "_req_rdy_busy"}, 64'(req_rdy), 64'd0);
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_latency"}, 64'(cyc - accept_cyc), 64'd32);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || !req_rdy) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_drained"}, 64'(sb.size()), 64'd0);
   endtask

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t dir[8];

   initial begin
      logic [63:0] held;
      int n;
      logic        s;
      logic [31:0] ra, rb;

      dir[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
      dir[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD};
      dir[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
      dir[3] = '{1'b1, 32'd5,          32'd0,        64'h00000005_FFFFFFFF};
      dir[4] = '{1'b0, 32'd5,          32'd0,        64'h00000005_FFFFFFFF};
      dir[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
      dir[6] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000};
      dir[7] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE, 64'h00000001_00000001};

      // Reset state
      #2;
      chk("rst_req_rdy",  64'(req_rdy),  64'd1);
      chk("rst_resp_val", 64'(resp_val), 64'd0);
      chk("rst_resp_msg", resp_msg,      64'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      resp_rdy = 1'b1;

      // Directed cases with latency and busy-ready checks
      foreach (dir[i]) begin
         send(dir[i].sgn, dir[i].a, dir[i].b, dir[i].exp);
         check_latency($sformatf("dir%0d", i));
         wait_drain($sformatf("dir%0d", i));
      end

      // Backpressure: DONE holds with a stable message
      resp_rdy = 1'b0;
      send(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);
      check_latency("bp");
      held = resp_msg;
      repeat (10) begin
         @(posedge clk); #1;
         chk("bp_resp_val", 64'(resp_val), 64'd1);
         chk("bp_resp_msg", resp_msg, held);
         chk("bp_req_rdy",  64'(req_rdy), 64'd0);
      end
      resp_rdy = 1'b1;
      wait_drain("bp");

      // Back-to-back random requests with random sink stalls
      rand_sink = 1'b1;
      for (int i = 0; i < 30; i++) begin
         s  = 1'($urandom_range(0, 1));
         ra = $urandom();
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFFFFFF;
            3: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            default: rb = $urandom();
         endcase
         send(s, ra, rb, model(s, ra, rb));
      end
      wait_drain("rand");
      rand_sink = 1'b0;
      @(posedge clk); #1;
      resp_rdy = 1'b1;

      // Reset mid-CALC drops the operation
      send(1'b0, 32'd1000, 32'd3, model(1'b0, 32'd1000, 32'd3));
      repeat (15) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midrst_req_rdy",  64'(req_rdy),  64'd1);
      chk("midrst_resp_val", 64'(resp_val), 64'd0);
      chk("midrst_resp_msg", resp_msg,      64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (resp_val) n++;
      end
      chk("midrst_no_resp", 64'(n), 64'd0);
      chk("midrst_idle",    64'(req_rdy), 64'd1);
      send(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF);
      check_latency("post_rst");
      wait_drain("post_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
